// File: rtl/cmult_fxp_pipe_if.sv
// Streaming port bundle for cmult_fxp_pipe: input sample/handshake and output result/handshake.
// slave is the multiplier's view, master is the upstream/downstream driver's view.
interface cmult_fxp_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_a_r;
  logic signed [WIDTH-1:0]     in_a_i;
  logic signed [WIDTH-1:0]     in_b_r;
  logic signed [WIDTH-1:0]     in_b_i;
  logic                        in_conj;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_r;
  logic signed [OUT_WIDTH-1:0] out_i;
  logic                        out_sat;
  logic                        out_last;

  modport slave (
    input  in_valid, in_a_r, in_a_i, in_b_r, in_b_i, in_conj, in_last, out_ready,
    output in_ready, out_valid, out_r, out_i, out_sat, out_last
  );

  modport master (
    output in_valid, in_a_r, in_a_i, in_b_r, in_b_i, in_conj, in_last, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_sat, out_last
  );
endinterface

// File: rtl/cmult_fxp_pipe.sv
// Pipelined complex fixed-point multiplier (a*b or a*conj(b)) with round-half-up, saturation and
// global-stall valid/ready. Define CMULT_ACCUM_EN to add a per-frame accumulator stage.
module cmult_fxp_pipe #(
  parameter int WIDTH       = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int FRAC        = 15,
  parameter int MULT_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  cmult_fxp_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int RW = PW + OUT_WIDTH + 2;

  // Returns {sat, value}; the wide working width keeps the rounding add from overflowing.
  function automatic logic [OUT_WIDTH:0] rndSat(input logic signed [PW:0] x);
    logic signed [RW-1:0] maxP, minN, t;
    maxP = (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
    minN = -maxP - RW'(1);
    t    = (RW'(x) + (RW'(1) <<< (FRAC - 1))) >>> FRAC;
    if (t > maxP)      rndSat = {1'b1, maxP[OUT_WIDTH-1:0]};
    else if (t < minN) rndSat = {1'b1, minN[OUT_WIDTH-1:0]};
    else               rndSat = {1'b0, t[OUT_WIDTH-1:0]};
  endfunction

  logic outValid, stall, adv;
  assign stall        = outValid && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;
  assign bus.out_valid = outValid;

  // ---- stages 1..MULT_CYCLES: four real products ----
  logic signed [PW-1:0]   rr_p0 [MULT_CYCLES];
  logic signed [PW-1:0]   ii_p0 [MULT_CYCLES];
  logic signed [PW-1:0]   ri_p0 [MULT_CYCLES];
  logic signed [PW-1:0]   ir_p0 [MULT_CYCLES];
  logic [MULT_CYCLES-1:0] vld_p0, conj_p0, last_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= '0;
      conj_p0 <= '0;
      last_p0 <= '0;
    end else if (adv) begin
      vld_p0[0]  <= bus.in_valid;
      conj_p0[0] <= bus.in_conj;
      last_p0[0] <= bus.in_valid && bus.in_last;
      for (int k = 1; k < MULT_CYCLES; k++) begin
        vld_p0[k]  <= vld_p0[k-1];
        conj_p0[k] <= conj_p0[k-1];
        last_p0[k] <= last_p0[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      rr_p0[0] <= PW'(bus.in_a_r) * PW'(bus.in_b_r);
      ii_p0[0] <= PW'(bus.in_a_i) * PW'(bus.in_b_i);
      ri_p0[0] <= PW'(bus.in_a_r) * PW'(bus.in_b_i);
      ir_p0[0] <= PW'(bus.in_a_i) * PW'(bus.in_b_r);
      for (int k = 1; k < MULT_CYCLES; k++) begin
        rr_p0[k] <= rr_p0[k-1];
        ii_p0[k] <= ii_p0[k-1];
        ri_p0[k] <= ri_p0[k-1];
        ir_p0[k] <= ir_p0[k-1];
      end
    end
  end

  // ---- stage MULT_CYCLES+1: combine at 2*WIDTH+1 bits ----
  logic signed [PW:0] rrExt, iiExt, riExt, irExt;
  logic signed [PW:0] re_p1, im_p1;
  logic               vld_p1, last_p1;

  assign rrExt = (PW+1)'(rr_p0[MULT_CYCLES-1]);
  assign iiExt = (PW+1)'(ii_p0[MULT_CYCLES-1]);
  assign riExt = (PW+1)'(ri_p0[MULT_CYCLES-1]);
  assign irExt = (PW+1)'(ir_p0[MULT_CYCLES-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1  <= vld_p0[MULT_CYCLES-1];
      last_p1 <= last_p0[MULT_CYCLES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      re_p1 <= conj_p0[MULT_CYCLES-1] ? (rrExt + iiExt) : (rrExt - iiExt);
      im_p1 <= conj_p0[MULT_CYCLES-1] ? (irExt - riExt) : (riExt + irExt);
    end
  end

  // ---- stage MULT_CYCLES+2: round and saturate ----
  logic [OUT_WIDTH:0]          rsR, rsI;
  logic signed [OUT_WIDTH-1:0] outR_p2, outI_p2;
  logic                        vld_p2, last_p2, sat_p2;

  assign rsR = rndSat(re_p1);
  assign rsI = rndSat(im_p1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      sat_p2  <= 1'b0;
      outR_p2 <= '0;
      outI_p2 <= '0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      sat_p2  <= vld_p1 && (rsR[OUT_WIDTH] || rsI[OUT_WIDTH]);
      outR_p2 <= rsR[OUT_WIDTH-1:0];
      outI_p2 <= rsI[OUT_WIDTH-1:0];
    end
  end

`ifdef CMULT_ACCUM_EN
  localparam int AW  = OUT_WIDTH + 8;
  localparam int AW1 = AW + 1;

  function automatic logic [OUT_WIDTH:0] satOut(input logic signed [AW:0] x);
    logic signed [AW:0] maxP, minN;
    maxP = (AW1'(1) <<< (OUT_WIDTH - 1)) - AW1'(1);
    minN = -maxP - AW1'(1);
    if (x > maxP)      satOut = {1'b1, maxP[OUT_WIDTH-1:0]};
    else if (x < minN) satOut = {1'b1, minN[OUT_WIDTH-1:0]};
    else               satOut = {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  // ---- stage MULT_CYCLES+3: frame accumulator, emits only on the last-tagged sample ----
  logic signed [AW-1:0]        accR_p3, accI_p3;
  logic                        accSat_p3;
  logic signed [AW:0]          sumR, sumI;
  logic [OUT_WIDTH:0]          fsR, fsI;
  logic signed [OUT_WIDTH-1:0] outR_p3, outI_p3;
  logic                        vld_p3, sat_p3;

  assign sumR = AW1'(accR_p3) + AW1'(outR_p2);
  assign sumI = AW1'(accI_p3) + AW1'(outI_p2);
  assign fsR  = satOut(sumR);
  assign fsI  = satOut(sumI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p3    <= 1'b0;
      sat_p3    <= 1'b0;
      outR_p3   <= '0;
      outI_p3   <= '0;
      accR_p3   <= '0;
      accI_p3   <= '0;
      accSat_p3 <= 1'b0;
    end else if (adv) begin
      vld_p3 <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        outR_p3   <= fsR[OUT_WIDTH-1:0];
        outI_p3   <= fsI[OUT_WIDTH-1:0];
        sat_p3    <= accSat_p3 || sat_p2 || fsR[OUT_WIDTH] || fsI[OUT_WIDTH];
        accR_p3   <= '0;
        accI_p3   <= '0;
        accSat_p3 <= 1'b0;
      end else if (vld_p2) begin
        accR_p3   <= sumR[AW-1:0];
        accI_p3   <= sumI[AW-1:0];
        accSat_p3 <= accSat_p3 || sat_p2;
      end
    end
  end

  assign outValid     = vld_p3;
  assign bus.out_r    = outR_p3;
  assign bus.out_i    = outI_p3;
  assign bus.out_sat  = sat_p3;
  assign bus.out_last = vld_p3;
`else
  assign outValid     = vld_p2;
  assign bus.out_r    = outR_p2;
  assign bus.out_i    = outI_p2;
  assign bus.out_sat  = sat_p2;
  assign bus.out_last = last_p2;
`endif
endmodule

// File: tb/tb_cmult_fxp_pipe.sv
// Bench for cmult_fxp_pipe: directed vectors, random streams with backpressure and reset,
// all checked against a plain-integer complex multiply/round/saturate model.
module tb_cmult_fxp_pipe;
  localparam int W    = 16;
  localparam int OW   = 16;
  localparam int FRAC = 15;
  localparam int MC   = 3;
`ifdef CMULT_ACCUM_EN
  localparam int L = MC + 3;
`else
  localparam int L = MC + 2;
`endif

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic        sat;
    logic        last;
  } res_t;

  typedef struct packed {
    logic [15:0] ar, ai, br, bi;
    logic        cj;
    logic [15:0] er, ei;
    logic        es;
  } dvec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nCmp  = 0;
  int   nBad  = 0;

  always #5 clk = ~clk;

  cmult_fxp_pipe_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus ();

  cmult_fxp_pipe #(.WIDTH(W), .OUT_WIDTH(OW), .FRAC(FRAC), .MULT_CYCLES(MC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic void refRound(input longint x, output logic [15:0] v, output logic s);
    longint t;
    t = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    s = 1'b0;
    if (t > 32767) begin
      v = 16'h7FFF; s = 1'b1;
    end else if (t < -32768) begin
      v = 16'h8000; s = 1'b1;
    end else begin
      v = t[15:0];
    end
  endfunction

  function automatic res_t refMul(input logic signed [15:0] ar, ai, br, bi, input logic cj, lst);
    longint rr, ii, ri, ir, re, im;
    res_t   e;
    logic   sr, si;
    rr = longint'(ar) * longint'(br);
    ii = longint'(ai) * longint'(bi);
    ri = longint'(ar) * longint'(bi);
    ir = longint'(ai) * longint'(br);
    re = cj ? rr + ii : rr - ii;
    im = cj ? ir - ri : ri + ir;
    refRound(re, e.r, sr);
    refRound(im, e.i, si);
    e.sat  = sr | si;
    e.last = lst;
    return e;
  endfunction

  function automatic logic [15:0] rndOp();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: drive inputs after the falling edge, sample outputs 1 ns later, then pass the rising edge.
  task automatic step(input logic v, input logic [15:0] ar, ai, br, bi, input logic cj, lst, ordy,
                      output logic oV, output logic iR, output res_t o);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a_r    = ar;
    bus.in_a_i    = ai;
    bus.in_b_r    = br;
    bus.in_b_i    = bi;
    bus.in_conj   = cj;
    bus.in_last   = lst;
    bus.out_ready = ordy;
    #1;
    oV     = bus.out_valid;
    iR     = bus.in_ready;
    o.r    = bus.out_r;
    o.i    = bus.out_i;
    o.sat  = bus.out_sat;
    o.last = bus.out_last;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    nCmp++; if (bus.out_r !== 16'h0) begin nBad++; $display("FAIL reset_out_r: got %h want 0000", bus.out_r); end
    nCmp++; if (bus.out_i !== 16'h0) begin nBad++; $display("FAIL reset_out_i: got %h want 0000", bus.out_i); end
    nCmp++; if (bus.out_sat !== 1'b0) begin nBad++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
    nCmp++; if (bus.out_last !== 1'b0) begin nBad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    reset = 1'b0;
    @(negedge clk);
    #1;
    nCmp++; if (bus.in_ready !== 1'b1) begin nBad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

`ifndef CMULT_ACCUM_EN
  task automatic test_directed();
    dvec_t vecs [7];
    logic  oV, iR;
    res_t  o, got;
    int    lat;
    vecs = '{
      '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 16'h4000, 16'h0000, 1'b0},
      '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b1, 16'h0000, 16'h4000, 1'b0},
      '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1},
      '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h8001, 16'h0000, 1'b0},
      '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0},
      '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0},
      '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1, 16'h8000, 16'hFFFE, 1'b1}
    };
    for (int n = 0; n < 7; n++) begin
      step(1'b1, vecs[n].ar, vecs[n].ai, vecs[n].br, vecs[n].bi, vecs[n].cj, 1'b0, 1'b1, oV, iR, o);
      lat = -1;
      got = '0;
      for (int k = 1; k <= 20; k++) begin
        step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, oV, iR, o);
        if (oV) begin
          lat = k; got = o;
          break;
        end
      end
      nCmp++; if (lat != L) begin nBad++; $display("FAIL dir%0d_latency: got %0d want %0d", n, lat, L); end
      nCmp++; if (got.r !== vecs[n].er) begin nBad++; $display("FAIL dir%0d_out_r: got %h want %h", n, got.r, vecs[n].er); end
      nCmp++; if (got.i !== vecs[n].ei) begin nBad++; $display("FAIL dir%0d_out_i: got %h want %h", n, got.i, vecs[n].ei); end
      nCmp++; if (got.sat !== vecs[n].es) begin nBad++; $display("FAIL dir%0d_out_sat: got %b want %b", n, got.sat, vecs[n].es); end
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t o, e;
    logic oV, iR, v, cj, lst;
    logic [15:0] ar, ai, br, bi;
    int sent = 0, got = 0, firstC = -1, lastC = -1;
    for (int c = 0; c < 80 && got < 20; c++) begin
      v = (sent < 20);
      ar = rndOp(); ai = rndOp(); br = rndOp(); bi = rndOp();
      cj = 1'($urandom_range(0, 1));
      lst = (sent == 19);
      step(v, ar, ai, br, bi, cj, lst, 1'b1, oV, iR, o);
      if (v && iR) begin
        q.push_back(refMul(ar, ai, br, bi, cj, lst));
        sent++;
      end
      if (oV) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        nCmp++;
        if (o !== e) begin
          nBad++;
          $display("FAIL b2b_sample%0d: got r=%h i=%h sat=%b last=%b want r=%h i=%h sat=%b last=%b",
                   got, o.r, o.i, o.sat, o.last, e.r, e.i, e.sat, e.last);
        end
        got++;
        if (firstC < 0) firstC = c;
        lastC = c;
      end
    end
    nCmp++; if (got != 20) begin nBad++; $display("FAIL b2b_count: got %0d want 20", got); end
    nCmp++; if (lastC - firstC != 19) begin nBad++; $display("FAIL b2b_span: got %0d want 19", lastC - firstC); end
  endtask

  task automatic test_stall();
    res_t q[$];
    res_t o, e, held;
    logic oV, iR, have, ordy, cj, lst;
    logic [15:0] ar, ai, br, bi;
    int sent = 0, got = 0, bubbleSat = 0;
    have = 1'b0; held = '0;
    ar = 0; ai = 0; br = 0; bi = 0; cj = 0; lst = 0;
    for (int c = 0; c < 800 && got < 60; c++) begin
      if (!have && sent < 60 && (c < 30 || $urandom_range(0, 9) < 7)) begin
        ar = rndOp(); ai = rndOp(); br = rndOp(); bi = rndOp();
        cj = 1'($urandom_range(0, 1));
        lst = (sent == 59);
        have = 1'b1;
      end
      if (c >= 10 && c <= 13) ordy = 1'b0;
      else if (c < 30)        ordy = 1'b1;
      else                    ordy = ($urandom_range(0, 9) < 7);
      if (have) step(1'b1, ar, ai, br, bi, cj, lst, ordy, oV, iR, o);
      else      step(1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1, ordy, oV, iR, o);
      if (c >= 10 && c <= 13) begin
        nCmp++; if (iR !== 1'b0 || oV !== 1'b1) begin nBad++; $display("FAIL stall_c%0d_ready: got in_ready=%b out_valid=%b want 0/1", c, iR, oV); end
        if (c == 10) held = o;
        else begin
          nCmp++; if (o !== held) begin nBad++; $display("FAIL stall_c%0d_hold: got r=%h i=%h want r=%h i=%h", c, o.r, o.i, held.r, held.i); end
        end
      end
      if (!oV && o.sat) bubbleSat++;
      if (have && iR) begin
        q.push_back(refMul(ar, ai, br, bi, cj, lst));
        sent++;
        have = 1'b0;
      end
      if (oV && ordy) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        nCmp++;
        if (o !== e) begin
          nBad++;
          $display("FAIL stall_sample%0d: got r=%h i=%h sat=%b last=%b want r=%h i=%h sat=%b last=%b",
                   got, o.r, o.i, o.sat, o.last, e.r, e.i, e.sat, e.last);
        end
        got++;
      end
    end
    nCmp++; if (got != 60) begin nBad++; $display("FAIL stall_count: got %0d want 60", got); end
    nCmp++; if (q.size() != 0) begin nBad++; $display("FAIL stall_leftover: got %0d want 0", q.size()); end
    nCmp++; if (bubbleSat != 0) begin nBad++; $display("FAIL bubble_sat: got %0d want 0", bubbleSat); end
  endtask
`else
  task automatic test_accum();
    res_t o, e, got;
    logic oV, iR, cj;
    logic [15:0] ar, ai, br, bi;
    int early = 0, cnt, lat, sr, si;
    res_t s;
    logic anySat;
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 16'h2000, 16'h0000, 16'h4000, 16'h0000, 1'b0, (n == 3), 1'b1, oV, iR, o);
      if (oV) early++;
    end
    cnt = 0; lat = -1; got = '0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, oV, iR, o);
      if (oV) begin
        cnt++;
        if (lat < 0) begin lat = k; got = o; end
      end
    end
    e = '{16'h4000, 16'h0000, 1'b0, 1'b1};
    nCmp++; if (early != 0) begin nBad++; $display("FAIL acc_early: got %0d want 0", early); end
    nCmp++; if (cnt != 1) begin nBad++; $display("FAIL acc_count: got %0d want 1", cnt); end
    nCmp++; if (lat != L) begin nBad++; $display("FAIL acc_latency: got %0d want %0d", lat, L); end
    nCmp++; if (got !== e) begin nBad++; $display("FAIL acc_frame1: got r=%h i=%h sat=%b last=%b want r=%h i=%h sat=%b last=%b", got.r, got.i, got.sat, got.last, e.r, e.i, e.sat, e.last); end
    sr = 0; si = 0; anySat = 1'b0;
    for (int n = 0; n < 3; n++) begin
      ar = rndOp(); ai = rndOp(); br = rndOp(); bi = rndOp();
      cj = 1'($urandom_range(0, 1));
      s = refMul(ar, ai, br, bi, cj, (n == 2));
      sr += int'(signed'(s.r)); si += int'(signed'(s.i)); anySat |= s.sat;
      step(1'b1, ar, ai, br, bi, cj, (n == 2), 1'b1, oV, iR, o);
    end
    e.last = 1'b1;
    if (sr > 32767) begin e.r = 16'h7FFF; anySat = 1'b1; end
    else if (sr < -32768) begin e.r = 16'h8000; anySat = 1'b1; end
    else e.r = 16'(sr);
    if (si > 32767) begin e.i = 16'h7FFF; anySat = 1'b1; end
    else if (si < -32768) begin e.i = 16'h8000; anySat = 1'b1; end
    else e.i = 16'(si);
    e.sat = anySat;
    cnt = 0; got = '0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, oV, iR, o);
      if (oV) begin
        if (cnt == 0) got = o;
        cnt++;
      end
    end
    nCmp++; if (cnt != 1) begin nBad++; $display("FAIL acc2_count: got %0d want 1", cnt); end
    nCmp++; if (got !== e) begin nBad++; $display("FAIL acc_frame2: got r=%h i=%h sat=%b last=%b want r=%h i=%h sat=%b last=%b", got.r, got.i, got.sat, got.last, e.r, e.i, e.sat, e.last); end
  endtask
`endif

  task automatic test_reset_inflight();
    res_t o;
    logic oV, iR;
    int stray = 0;
    for (int n = 0; n < L; n++)
      step(1'b1, rndOp(), rndOp(), rndOp(), rndOp(), 1'b0, 1'b1, 1'b1, oV, iR, o);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    nCmp++; if (bus.out_valid !== 1'b1) begin nBad++; $display("FAIL inflight_pre_valid: got %b want 1", bus.out_valid); end
    #2 reset = 1'b1;
    #1;
    nCmp++; if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL inflight_async_valid: got %b want 0", bus.out_valid); end
    nCmp++; if (bus.out_r !== 16'h0 || bus.out_sat !== 1'b0 || bus.out_last !== 1'b0) begin
      nBad++; $display("FAIL inflight_async_data: got r=%h sat=%b last=%b want 0000/0/0", bus.out_r, bus.out_sat, bus.out_last);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, oV, iR, o);
      if (oV) stray++;
    end
    nCmp++; if (stray != 0) begin nBad++; $display("FAIL inflight_stale: got %0d outputs want 0", stray); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a_r    = '0;
    bus.in_a_i    = '0;
    bus.in_b_r    = '0;
    bus.in_b_i    = '0;
    bus.in_conj   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
`ifdef CMULT_ACCUM_EN
    test_accum();
`else
    test_directed();
    test_back_to_back();
    test_stall();
`endif
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", nCmp);
    $fatal(1);
  end
endmodule
